mem_wb_datapath: RTL and testbench

MEM-stage datapath sitting directly downstream of the EX/MEM pipeline register and feeding the write-back path. It owns the 512-byte big-endian data RAM, performs byte/halfword/word loads and stores with optional sign extension, and registers the write-back value, destination register and enables toward the register file. It also detects misaligned accesses, suppresses them and flags them to the core.

---
 rtl/mem_wb_datapath.sv | 234 +++++++++++++++++++++++
 tb/tb_mem_wb_datapath.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_datapath.sv
// ---------------------------------------------------------------------------------------------
// mem_wb_datapath
//
// MEM-stage datapath between the EX/MEM pipeline register and the register-file write-back.
// Owns a byte-addressed, big-endian data RAM and performs byte/halfword/word loads and stores
// with optional sign extension of sub-word loads. The write-back value, destination register
// and write enables are registered toward the register file (one cycle of latency).
// Misaligned accesses are suppressed (no RAM write, load value 0, no register-file write) and
// reported through a one-cycle pulse plus a sticky flag that only reset clears.
//
// Ports:
//   clk              rising-edge clock
//   reset            asynchronous, active-low reset
//   mem_enable       access request this cycle
//   mem_rw           1 = store, 0 = load
//   mem_size         00 byte, 01 halfword, 10 word, 11 reserved (always misaligned)
//   mem_se           sign-extend byte/halfword loads
//   load_instr       write back loaded data (1) or alu_result (0)
//   rf_enable_in     register-file write request
//   hi_enable_in     HI write request
//   lo_enable_in     LO write request
//   rd_in            destination register number
//   alu_result       effective address / ALU result
//   store_data       store source operand
//   mem_fwd_data     combinational MEM-stage value for the forwarding muxes
//   wb_data          registered write-back value
//   wb_rd            registered destination register
//   wb_rf_enable     registered register-file write enable (0 for a misaligned access)
//   wb_hi_enable     registered HI write enable
//   wb_lo_enable     registered LO write enable
//   misalign         registered one-cycle pulse for a suppressed access
//   misalign_sticky  set by any misaligned access, cleared only by reset
// ---------------------------------------------------------------------------------------------
module mem_wb_datapath #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DEPTH  = 512
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_enable,
    input  logic        mem_rw,
    input  logic [1:0]  mem_size,
    input  logic        mem_se,
    input  logic        load_instr,
    input  logic        rf_enable_in,
    input  logic        hi_enable_in,
    input  logic        lo_enable_in,
    input  logic [4:0]  rd_in,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    output logic [31:0] mem_fwd_data,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_rf_enable,
    output logic        wb_hi_enable,
    output logic        wb_lo_enable,
    output logic        misalign,
    output logic        misalign_sticky
);

    localparam logic [1:0] SizeByte = 2'b00;
    localparam logic [1:0] SizeHalf = 2'b01;
    localparam logic [1:0] SizeWord = 2'b10;

    // Byte array; name kept so the environment can preload it hierarchically.
    logic [7:0] Mem [DEPTH];

    // ------------------------------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------------------------------
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-3:0] word_idx;
    logic [1:0]        lane;

    // Upper address bits are deliberately ignored: the RAM aliases across the 32-bit space.
    logic unused_addr_hi;
    assign unused_addr_hi = ^alu_result[31:ADDR_W];

    assign addr     = alu_result[ADDR_W-1:0];
    assign word_idx = addr[ADDR_W-1:2];
    assign lane     = addr[1:0];

    // ------------------------------------------------------------------------------------------
    // Alignment check and access qualification
    // ------------------------------------------------------------------------------------------
    logic size_bad;
    logic mis_now;
    logic do_load;
    logic do_store;

    always_comb begin
        size_bad = 1'b0;
        unique case (mem_size)
            SizeByte: size_bad = 1'b0;
            SizeHalf: size_bad = lane[0];
            SizeWord: size_bad = |lane;
            default:  size_bad = 1'b1;
        endcase
    end

    assign mis_now = mem_enable & size_bad;
    assign do_load = mem_enable & ~mem_rw & ~size_bad;
    // A store presented while reset is held must not reach the array.
    assign do_store = mem_enable & mem_rw & ~size_bad & reset;

    // ------------------------------------------------------------------------------------------
    // Load path: read the whole containing word, then pick and extend the addressed lane(s).
    // Lane 0 is the most significant byte (big-endian).
    // ------------------------------------------------------------------------------------------
    logic [31:0] rd_word;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_val;

    assign rd_word = {Mem[{word_idx, 2'd0}], Mem[{word_idx, 2'd1}],
                      Mem[{word_idx, 2'd2}], Mem[{word_idx, 2'd3}]};

    always_comb begin
        rd_byte = 8'h00;
        unique case (lane)
            2'd0: rd_byte = rd_word[31:24];
            2'd1: rd_byte = rd_word[23:16];
            2'd2: rd_byte = rd_word[15:8];
            2'd3: rd_byte = rd_word[7:0];
            default: rd_byte = 8'h00;
        endcase
    end

    assign rd_half = lane[1] ? rd_word[15:0] : rd_word[31:16];

    always_comb begin
        load_val = 32'h0;
        if (do_load) begin
            unique case (mem_size)
                SizeByte: load_val = {{24{mem_se & rd_byte[7]}}, rd_byte};
                SizeHalf: load_val = {{16{mem_se & rd_half[15]}}, rd_half};
                SizeWord: load_val = rd_word;
                default:  load_val = 32'h0;
            endcase
        end
    end

    assign mem_fwd_data = load_instr ? load_val : alu_result;

    // ------------------------------------------------------------------------------------------
    // Store path: replicate the source across lanes and enable only the addressed byte(s).
    // byte_we[3] is lane 0 (the MSB byte of the word).
    // ------------------------------------------------------------------------------------------
    logic [3:0]  byte_we;
    logic [31:0] wr_word;

    always_comb begin
        byte_we = 4'b0000;
        wr_word = 32'h0;
        if (do_store) begin
            unique case (mem_size)
                SizeByte: begin
                    wr_word = {4{store_data[7:0]}};
                    byte_we = 4'b1000 >> lane;
                end
                SizeHalf: begin
                    wr_word = {2{store_data[15:0]}};
                    byte_we = lane[1] ? 4'b0011 : 4'b1100;
                end
                SizeWord: begin
                    wr_word = store_data;
                    byte_we = 4'b1111;
                end
                default: begin
                    wr_word = 32'h0;
                    byte_we = 4'b0000;
                end
            endcase
        end
    end

    // RAM contents survive reset, so this block has no reset branch.
    always_ff @(posedge clk) begin
        if (byte_we[3]) Mem[{word_idx, 2'd0}] <= wr_word[31:24];
        if (byte_we[2]) Mem[{word_idx, 2'd1}] <= wr_word[23:16];
        if (byte_we[1]) Mem[{word_idx, 2'd2}] <= wr_word[15:8];
        if (byte_we[0]) Mem[{word_idx, 2'd3}] <= wr_word[7:0];
    end

    // ------------------------------------------------------------------------------------------
    // MEM/WB pipeline register
    // ------------------------------------------------------------------------------------------
    logic [31:0] wb_data_d, wb_data_q;
    logic [4:0]  wb_rd_d, wb_rd_q;
    logic        wb_rf_enable_d, wb_rf_enable_q;
    logic        wb_hi_enable_d, wb_hi_enable_q;
    logic        wb_lo_enable_d, wb_lo_enable_q;
    logic        misalign_d, misalign_q;
    logic        sticky_d, sticky_q;

    always_comb begin
        wb_data_d      = mem_fwd_data;
        wb_rd_d        = rd_in;
        wb_rf_enable_d = rf_enable_in & ~mis_now;
        wb_hi_enable_d = hi_enable_in;
        wb_lo_enable_d = lo_enable_in;
        misalign_d     = mis_now;
        sticky_d       = sticky_q | mis_now;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_data_q      <= 32'h0;
            wb_rd_q        <= 5'd0;
            wb_rf_enable_q <= 1'b0;
            wb_hi_enable_q <= 1'b0;
            wb_lo_enable_q <= 1'b0;
            misalign_q     <= 1'b0;
            sticky_q       <= 1'b0;
        end else begin
            wb_data_q      <= wb_data_d;
            wb_rd_q        <= wb_rd_d;
            wb_rf_enable_q <= wb_rf_enable_d;
            wb_hi_enable_q <= wb_hi_enable_d;
            wb_lo_enable_q <= wb_lo_enable_d;
            misalign_q     <= misalign_d;
            sticky_q       <= sticky_d;
        end
    end

    assign wb_data         = wb_data_q;
    assign wb_rd           = wb_rd_q;
    assign wb_rf_enable    = wb_rf_enable_q;
    assign wb_hi_enable    = wb_hi_enable_q;
    assign wb_lo_enable    = wb_lo_enable_q;
    assign misalign        = misalign_q;
    assign misalign_sticky = sticky_q;

endmodule

// File: tb/tb_mem_wb_datapath.sv
// ---------------------------------------------------------------------------------------------
// tb_mem_wb_datapath
//
// Self-checking bench for mem_wb_datapath. A byte-array reference model computes load values,
// store effects and flag behaviour with plain arithmetic; directed cases cover the main
// scenarios and a randomized phase exercises mixed traffic.
// ---------------------------------------------------------------------------------------------
module tb_mem_wb_datapath;

    logic        clk;
    logic        reset;
    logic        mem_enable;
    logic        mem_rw;
    logic [1:0]  mem_size;
    logic        mem_se;
    logic        load_instr;
    logic        rf_enable_in;
    logic        hi_enable_in;
    logic        lo_enable_in;
    logic [4:0]  rd_in;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [31:0] mem_fwd_data;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_rf_enable;
    logic        wb_hi_enable;
    logic        wb_lo_enable;
    logic        misalign;
    logic        misalign_sticky;

    mem_wb_datapath #(
        .ADDR_W(9),
        .DEPTH (512)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_enable     (mem_enable),
        .mem_rw         (mem_rw),
        .mem_size       (mem_size),
        .mem_se         (mem_se),
        .load_instr     (load_instr),
        .rf_enable_in   (rf_enable_in),
        .hi_enable_in   (hi_enable_in),
        .lo_enable_in   (lo_enable_in),
        .rd_in          (rd_in),
        .alu_result     (alu_result),
        .store_data     (store_data),
        .mem_fwd_data   (mem_fwd_data),
        .wb_data        (wb_data),
        .wb_rd          (wb_rd),
        .wb_rf_enable   (wb_rf_enable),
        .wb_hi_enable   (wb_hi_enable),
        .wb_lo_enable   (wb_lo_enable),
        .misalign       (misalign),
        .misalign_sticky(misalign_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] ref_mem [512];
    logic       ref_sticky;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic bit model_misaligned(input logic [1:0] sz, input int a);
        case (sz)
            2'd0:    return 1'b0;
            2'd1:    return (a % 2) != 0;
            2'd2:    return (a % 4) != 0;
            default: return 1'b1;
        endcase
    endfunction

    // Big-endian read: byte at a is most significant.
    function automatic logic [31:0] model_load(input int a, input logic [1:0] sz, input logic se);
        logic [31:0] v;
        v = 32'h0;
        case (sz)
            2'd0: begin
                v = 32'(ref_mem[a]);
                if (se && v >= 128) v = v + 32'hFFFF_FF00;
            end
            2'd1: begin
                v = 32'(ref_mem[a]) * 256 + 32'(ref_mem[a + 1]);
                if (se && v >= 32768) v = v + 32'hFFFF_0000;
            end
            2'd2: begin
                v = ((32'(ref_mem[a]) * 256 + 32'(ref_mem[a + 1])) * 256
                     + 32'(ref_mem[a + 2])) * 256 + 32'(ref_mem[a + 3]);
            end
            default: v = 32'h0;
        endcase
        return v;
    endfunction

    task automatic model_store(input int a, input logic [1:0] sz, input logic [31:0] sd);
        int n;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        for (int k = 0; k < n; k++) begin
            ref_mem[a + k] = 8'((sd >> (8 * (n - 1 - k))) & 32'hFF);
        end
    endtask

    // Present one instruction (called shortly after a rising edge), check the combinational
    // forwarding value, cross the next rising edge, then check the registered outputs.
    task automatic step(input logic en, input logic rw, input logic [1:0] sz, input logic se,
                        input logic li, input logic rfe, input logic hie, input logic loe,
                        input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] sd,
                        input string tag);
        int          a;
        bit          mis;
        logic [31:0] exp_load;
        logic [31:0] exp_fwd;
        mem_enable   = en;
        mem_rw       = rw;
        mem_size     = sz;
        mem_se       = se;
        load_instr   = li;
        rf_enable_in = rfe;
        hi_enable_in = hie;
        lo_enable_in = loe;
        rd_in        = rd;
        alu_result   = alu;
        store_data   = sd;
        #1;
        a        = int'(alu % 512);
        mis      = en && model_misaligned(sz, a);
        exp_load = (en && !rw && !mis) ? model_load(a, sz, se) : 32'h0;
        exp_fwd  = li ? exp_load : alu;
        check_val({tag, ".fwd"}, mem_fwd_data, exp_fwd);
        if (en && rw && !mis) model_store(a, sz, sd);
        if (mis) ref_sticky = 1'b1;
        @(posedge clk);
        #1;
        check_val({tag, ".wb_data"}, wb_data, exp_fwd);
        check_val({tag, ".wb_rd"}, 32'(wb_rd), 32'(rd));
        check_val({tag, ".wb_rf"}, 32'(wb_rf_enable), 32'(rfe && !mis));
        check_val({tag, ".wb_hi"}, 32'(wb_hi_enable), 32'(hie));
        check_val({tag, ".wb_lo"}, 32'(wb_lo_enable), 32'(loe));
        check_val({tag, ".misalign"}, 32'(misalign), 32'(mis));
        check_val({tag, ".sticky"}, 32'(misalign_sticky), 32'(ref_sticky));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, ".wb_data"}, wb_data, 32'h0);
        check_val({tag, ".wb_rd"}, 32'(wb_rd), 32'h0);
        check_val({tag, ".wb_en"}, 32'({wb_rf_enable, wb_hi_enable, wb_lo_enable}), 32'h0);
        check_val({tag, ".misalign"}, 32'(misalign), 32'h0);
        check_val({tag, ".sticky"}, 32'(misalign_sticky), 32'h0);
    endtask

    initial begin
        logic [1:0]  sz;
        logic        en;
        logic        rw;
        logic [31:0] alu;

        reset        = 1'b0;
        mem_enable   = 1'b0;
        mem_rw       = 1'b0;
        mem_size     = 2'd0;
        mem_se       = 1'b0;
        load_instr   = 1'b0;
        rf_enable_in = 1'b0;
        hi_enable_in = 1'b0;
        lo_enable_in = 1'b0;
        rd_in        = 5'd0;
        alu_result   = 32'h0000_1234;
        store_data   = 32'h0;
        ref_sticky   = 1'b0;

        // RAM is not reset: preload DUT and model with the same random image.
        for (int i = 0; i < 512; i++) begin
            ref_mem[i] = 8'($urandom_range(0, 255));
            dut.Mem[i] = ref_mem[i];
        end

        // Reset state, forwarding path live during reset.
        #2;
        check_reset_outputs("reset");
        check_val("reset.fwd", mem_fwd_data, 32'h0000_1234);
        @(posedge clk);
        @(posedge clk);
        #1;
        check_reset_outputs("reset_hold");
        reset = 1'b1;

        // Word store then word load.
        step(1, 1, 2'd2, 0, 0, 0, 0, 0, 5'd0, 32'h010, 32'hDEAD_BEEF, "st_w");
        step(1, 0, 2'd2, 0, 1, 1, 0, 0, 5'd3, 32'h010, 32'h0, "ld_w");
        check_val("ld_w.const", wb_data, 32'hDEAD_BEEF);
        check_val("mem10", 32'(dut.Mem[16]), 32'hDE);
        check_val("mem11", 32'(dut.Mem[17]), 32'hAD);
        check_val("mem12", 32'(dut.Mem[18]), 32'hBE);
        check_val("mem13", 32'(dut.Mem[19]), 32'hEF);

        // Sub-word loads with and without sign extension.
        step(1, 0, 2'd0, 0, 1, 1, 0, 0, 5'd4, 32'h011, 32'h0, "lbu");
        check_val("lbu.const", wb_data, 32'h0000_00AD);
        step(1, 0, 2'd0, 1, 1, 1, 0, 0, 5'd4, 32'h011, 32'h0, "lb");
        check_val("lb.const", wb_data, 32'hFFFF_FFAD);
        step(1, 0, 2'd1, 1, 1, 1, 0, 0, 5'd4, 32'h012, 32'h0, "lh");
        check_val("lh.const", wb_data, 32'hFFFF_BEEF);

        // Byte and halfword stores merge into the word.
        step(1, 1, 2'd0, 0, 0, 0, 0, 0, 5'd0, 32'h013, 32'h1234_5655, "sb");
        step(1, 0, 2'd2, 0, 1, 1, 0, 0, 5'd6, 32'h010, 32'h0, "ld_sb");
        check_val("ld_sb.const", wb_data, 32'hDEAD_BE55);
        step(1, 1, 2'd1, 0, 0, 0, 0, 0, 5'd0, 32'h010, 32'hABCD_1234, "sh");
        step(1, 0, 2'd2, 0, 1, 1, 0, 0, 5'd6, 32'h010, 32'h0, "ld_sh");
        check_val("ld_sh.const", wb_data, 32'h1234_BE55);

        // Misaligned word load: suppressed, one-cycle pulse, sticky stays.
        step(1, 0, 2'd2, 0, 1, 1, 0, 0, 5'd7, 32'h011, 32'h0, "mis_lw");
        check_val("mis_lw.const", 32'({wb_rf_enable, misalign, misalign_sticky}), 32'b011);
        step(0, 0, 2'd0, 0, 0, 1, 0, 0, 5'd5, 32'h7, 32'h0, "addiu");
        check_val("addiu.const", 32'({misalign, misalign_sticky}), 32'b01);
        check_val("addiu.data", wb_data, 32'h7);

        // Misaligned stores back to back: pulse held, no RAM write.
        step(1, 1, 2'd1, 0, 0, 1, 1, 0, 5'd8, 32'h021, 32'hFFFF_FFFF, "mis_sh");
        step(1, 1, 2'd3, 0, 0, 1, 0, 1, 5'd9, 32'h020, 32'hFFFF_FFFF, "mis_rsv");
        check_val("mis_rsv.mem", 32'(dut.Mem[33]), 32'(ref_mem[33]));

        // Address alias: 0x210 maps onto 0x010.
        step(1, 1, 2'd2, 0, 0, 0, 0, 0, 5'd0, 32'h210, 32'hCAFE_F00D, "alias_st");
        step(1, 0, 2'd2, 0, 1, 1, 0, 0, 5'd10, 32'h010, 32'h0, "alias_ld");
        check_val("alias_ld.const", wb_data, 32'hCAFE_F00D);

        // Randomized mixed traffic.
        for (int n = 0; n < 300; n++) begin
            sz  = 2'($urandom_range(0, 3));
            en  = ($urandom_range(0, 9) != 0);
            rw  = 1'($urandom_range(0, 1));
            alu = $urandom;
            if ($urandom_range(0, 9) < 7) begin
                if (sz == 2'd1) alu[0] = 1'b0;
                if (sz == 2'd2) alu[1:0] = 2'b00;
            end
            if (sz == 2'd3 && $urandom_range(0, 3) != 0) sz = 2'd2;
            step(en, rw, sz, 1'($urandom_range(0, 1)), en && !rw,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), alu, $urandom, "rnd");
        end

        // Reset asserted with a store pending: outputs clear at once, RAM untouched.
        mem_enable = 1'b1;
        mem_rw     = 1'b1;
        mem_size   = 2'd2;
        alu_result = 32'h020;
        store_data = 32'h1122_3344;
        load_instr = 1'b0;
        reset      = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        @(posedge clk);
        #1;
        for (int i = 32; i < 36; i++) begin
            check_val("mid_reset.mem", 32'(dut.Mem[i]), 32'(ref_mem[i]));
        end
        check_reset_outputs("mid_reset_edge");
        reset      = 1'b1;
        ref_sticky = 1'b0;
        step(1, 0, 2'd2, 0, 1, 1, 0, 0, 5'd11, 32'h020, 32'h0, "post_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
